cfg_spi_loader: RTL and testbench
=================================

CFG_SPI_LOADER -- requirements
Module: cfg_spi_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of buffered config byte writes (power of two, ≥2).
REQ-002 SHALL have parameter STROBE_CYCLES, default 4: clk cycles cfg_strobe is held high, then held low, per write (≥3).
REQ-003 SHALL use one clock and an asynchronous, active-high reset, on ports named as follows:
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 spi_sclk  input  1  SPI clock from host MCU, asynchronous to clk, mode 0.
REQ-007 spi_mosi  input  1  SPI data, MSB first, asynchronous.
REQ-008 spi_cs_n  input  1  SPI frame select, active low, asynchronous.
REQ-009 cfg_addr  output  4  [3:1] config word address, [0] byte select (1 = high byte); drives synth ui_in[3:0].
REQ-010 cfg_data  output  8  config byte; drives synth uio_in.
REQ-011 cfg_strobe  output  1  write strobe; drives synth ui_in[7].
REQ-012 busy  output  1  high while the FIFO is non-empty or a write sequence is in progress.
REQ-013 overflow  output  1  sticky flag: a received byte was dropped because the FIFO was full.

Function
REQ-014 spi_sclk, spi_mosi, spi_cs_n SHALL each pass a 2-flop synchronizer; all SPI logic SHALL use the synchronized values only.
REQ-015 A bit SHALL be sampled from synchronized mosi on each synchronized sclk rising edge while synchronized cs_n is low; supported sclk frequency ≤ clk/4.
REQ-016 Synchronized cs_n high SHALL clear the bit counter and return the receiver to expect-header; a partial byte SHALL be discarded without any FIFO push.
REQ-017 The first complete byte of a frame SHALL be the header; header[3:0] loads the byte-address pointer; header[7:4] SHALL be ignored; the header SHALL NOT be pushed.
REQ-018 Each subsequent complete byte SHALL be pushed as {pointer, byte} in the cycle after its 8th sampling edge; the pointer SHALL then increment modulo 16 (15 wraps to 0).
REQ-019 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle; otherwise the byte SHALL be dropped, overflow set, and the pointer still incremented.
REQ-020 Write FSM states: IDLE, SETUP, HIGH, HOLD.
REQ-021 IDLE: if FIFO non-empty, pop the head into the cfg_addr/cfg_data output registers and go to SETUP; else stay.
REQ-022 SETUP lasts 1 cycle with cfg_strobe low, then HIGH.
REQ-023 HIGH lasts exactly STROBE_CYCLES cycles with cfg_strobe high, then HOLD.
REQ-024 HOLD lasts exactly STROBE_CYCLES cycles with cfg_strobe low, then IDLE.
REQ-025 cfg_addr/cfg_data SHALL remain stable from SETUP through the end of HOLD and SHALL keep their last value in IDLE.
REQ-026 A write sequence SHALL take 1+2*STROBE_CYCLES cycles from the pop to the return to IDLE; the next pop can occur in the IDLE cycle that follows, giving 2+2*STROBE_CYCLES cycles per write back-to-back.
REQ-027 The FIFO SHALL preserve order; push and pop in the same cycle SHALL both take effect.
REQ-028 SPI reception SHALL be independent of the FSM; cs_n toggling SHALL NOT disturb a write sequence in progress.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Asserting reset SHALL immediately force cfg_strobe=0, cfg_addr=0, cfg_data=0, busy=0, overflow=0, FSM=IDLE, FIFO empty, receiver in expect-header with pointer 0, and synchronizers to the idle levels sclk=0, mosi=0, cs_n=1.
REQ-031 Reset during HIGH SHALL drop cfg_strobe in the same cycle; no partial write SHALL resume after reset release.
REQ-032 After reset release, the first sampled sclk edge SHALL NOT be counted unless synchronized cs_n is low.

Structure
REQ-033 A shared package cfg_loader_pkg SHALL hold the FSM state enum, the FIFO entry width (12 = 4 addr + 8 data), and default parameter constants.
REQ-034 The FIFO SHALL be one sub-module cfg_fifo (synchronous, parameterized depth/width, full/empty flags, simultaneous push/pop).

Verification
REQ-035 Frame header 0x04 + data 0xA5 -> one write: cfg_addr=4, cfg_data=0xA5, strobe high 4 cycles after 1 setup cycle, then low 4 cycles; busy falls after HOLD.
REQ-036 Header 0x0E + 3 data bytes 0x11,0x22,0x33 -> writes at addr 14, 15, 0 in that order, back-to-back at 10-cycle spacing.
REQ-037 cs_n raised after 5 bits of a data byte -> no write, pointer unchanged; next frame header accepted normally.
REQ-038 6 data bytes sent while the FSM is busy with FIFO_DEPTH=4 -> overflow=1 once a byte is dropped; the writes actually performed match the accepted bytes in order; overflow stays set.
REQ-039 Reset asserted mid-HIGH -> cfg_strobe=0 in the same cycle, FIFO empty, no further strobes after release.
REQ-040 End-to-end with the synth's config port, a deferred write (sweep override active) -> the byte is still written, because cfg_strobe is held ≥3 cycles.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_loader_pkg
//  Purpose  : Shared types and constants for the SPI configuration loader:
//             write-FSM state encoding, FIFO entry layout and default
//             parameter values.
//  Revision : 1.0 - initial release
// ============================================================================
package cfg_loader_pkg;

   localparam int c_addr_w  = 4;
   localparam int c_data_w  = 8;
   localparam int c_entry_w = c_addr_w + c_data_w;   // {addr[3:0], data[7:0]}

   localparam int c_fifo_depth_def    = 4;
   localparam int c_strobe_cycles_def = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_HOLD  = 2'd3
   } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_fifo
//  Purpose  : Synchronous FIFO with full/empty flags. A push into a full FIFO
//             is accepted when a pop happens in the same cycle; a push with
//             no room is silently ignored (the caller flags the drop).
//  Ports    : clk, reset       - clock, asynchronous active-high reset
//             push, push_data  - write request and entry
//             pop              - remove head (ignored when empty)
//             pop_data         - current head entry (valid when !empty)
//             full, empty      - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_fifo
   import cfg_loader_pkg::*;
#(
   parameter int DEPTH = c_fifo_depth_def,   // power of two, >= 2
   parameter int WIDTH = c_entry_w
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int                 c_ptr_w    = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]   c_full_cnt = DEPTH[c_ptr_w:0];

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;

   logic w_do_pop;
   logic w_do_push;

   assign empty    = (r_count == '0);
   assign full     = (r_count == c_full_cnt);
   assign pop_data = r_mem[r_rd_ptr];

   assign w_do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push needs.
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/cfg_spi_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_spi_loader
//  Purpose  : Receives configuration bytes from a host over SPI (mode 0,
//             MSB first), buffers them and replays each one to the synth
//             config port as a slow, fully-framed write strobe.
//             Frame = header byte (low nibble = start address) followed by
//             data bytes written to consecutive addresses (mod 16).
//  Ports    : clk, reset            - system clock, async active-high reset
//             spi_sclk/mosi/cs_n    - asynchronous SPI inputs
//             cfg_addr[3:0]         - config address ([0] = byte select)
//             cfg_data[7:0]         - config byte
//             cfg_strobe            - write strobe
//             busy                  - FIFO non-empty or write in progress
//             overflow              - sticky: a byte was dropped (FIFO full)
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_spi_loader
   import cfg_loader_pkg::*;
#(
   parameter int FIFO_DEPTH    = c_fifo_depth_def,     // power of two, >= 2
   parameter int STROBE_CYCLES = c_strobe_cycles_def   // >= 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                spi_sclk,
   input  logic                spi_mosi,
   input  logic                spi_cs_n,
   output logic [c_addr_w-1:0] cfg_addr,
   output logic [c_data_w-1:0] cfg_data,
   output logic                cfg_strobe,
   output logic                busy,
   output logic                overflow
);

   localparam int                 c_cnt_w    = $clog2(STROBE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STROBE_CYCLES - 1);

   // ------------------------------------------------------------------
   // Input synchronizers; reset to the idle bus levels.
   // ------------------------------------------------------------------
   logic [1:0] r_sclk_sync;
   logic [1:0] r_mosi_sync;
   logic [1:0] r_cs_sync;
   logic       r_sclk_prev;
   logic       w_sclk_rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sclk_sync <= 2'b00;
         r_mosi_sync <= 2'b00;
         r_cs_sync   <= 2'b11;
         r_sclk_prev <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
         r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
         r_cs_sync   <= {r_cs_sync[0],   spi_cs_n};
         r_sclk_prev <= r_sclk_sync[1];
      end
   end

   assign w_sclk_rise = r_sclk_sync[1] && !r_sclk_prev;

   // ------------------------------------------------------------------
   // SPI receiver: bit counter, shift register, header/pointer tracking.
   // The push request is registered, so it lands the cycle after the
   // 8th sampling edge.
   // ------------------------------------------------------------------
   logic [2:0]           r_bit_cnt;
   logic [6:0]           r_shift;
   logic                 r_have_hdr;
   logic [c_addr_w-1:0]  r_ptr;
   logic                 r_push_req;
   logic [c_entry_w-1:0] r_push_entry;
   logic [7:0]           w_byte;

   assign w_byte = {r_shift, r_mosi_sync[1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt    <= 3'd0;
         r_shift      <= 7'd0;
         r_have_hdr   <= 1'b0;
         r_ptr        <= '0;
         r_push_req   <= 1'b0;
         r_push_entry <= '0;
      end else begin
         r_push_req <= 1'b0;
         if (r_cs_sync[1]) begin
            // Deselect drops any partial byte and re-arms the header.
            r_bit_cnt  <= 3'd0;
            r_have_hdr <= 1'b0;
         end else if (w_sclk_rise) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               if (!r_have_hdr) begin
                  r_ptr      <= w_byte[3:0];
                  r_have_hdr <= 1'b1;
               end else begin
                  r_push_req   <= 1'b1;
                  r_push_entry <= {r_ptr, w_byte};
                  // Advances even if the FIFO later rejects this byte.
                  r_ptr        <= r_ptr + 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Write buffer
   // ------------------------------------------------------------------
   logic [c_entry_w-1:0] w_fifo_head;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_fifo_pop;

   cfg_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (c_entry_w)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (r_push_req),
      .push_data (r_push_entry),
      .pop       (w_fifo_pop),
      .pop_data  (w_fifo_head),
      .full      (w_fifo_full),
      .empty     (w_fifo_empty)
   );

   // ------------------------------------------------------------------
   // Write FSM
   // ------------------------------------------------------------------
   wr_state_t           r_state;
   wr_state_t           w_next_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [c_cnt_w-1:0]  w_cnt_next;
   logic [c_addr_w-1:0] r_cfg_addr;
   logic [c_data_w-1:0] r_cfg_data;
   logic                r_cfg_strobe;
   logic                r_busy;
   logic                r_overflow;
   logic                w_strobe_d;
   logic                w_busy_d;

   // State register plus the registered outputs it drives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_cfg_addr   <= '0;
         r_cfg_data   <= '0;
         r_cfg_strobe <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_cnt        <= w_cnt_next;
         r_cfg_strobe <= w_strobe_d;
         r_busy       <= w_busy_d;
         if (w_fifo_pop) begin
            {r_cfg_addr, r_cfg_data} <= w_fifo_head;
         end
      end
   end

   // Next-state logic; r_cnt times the HIGH and HOLD phases.
   always_comb begin
      w_next_state = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_next_state = ST_SETUP;
            end
         end
         ST_SETUP: begin
            w_next_state = ST_HIGH;
            w_cnt_next   = '0;
         end
         ST_HIGH: begin
            if (r_cnt == c_cnt_last) begin
               w_next_state = ST_HOLD;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_HOLD: begin
            if (r_cnt == c_cnt_last) begin
               w_next_state = ST_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Output decode; the strobe register follows the state being entered
   // so cfg_strobe is high exactly while the FSM sits in HIGH.
   always_comb begin
      w_fifo_pop = (r_state == ST_IDLE) && !w_fifo_empty;
      w_strobe_d = (w_next_state == ST_HIGH);
      w_busy_d   = (r_state != ST_IDLE) || !w_fifo_empty;
   end

   // Sticky drop flag: push with no room and no simultaneous pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (r_push_req && w_fifo_full && !w_fifo_pop) begin
         r_overflow <= 1'b1;
      end
   end

   assign cfg_addr   = r_cfg_addr;
   assign cfg_data   = r_cfg_data;
   assign cfg_strobe = r_cfg_strobe;
   assign busy       = r_busy;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cfg_spi_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_spi_loader
//  Purpose  : Self-checking bench for cfg_spi_loader. Two instances share
//             sclk/mosi with separate chip selects: one at default timing,
//             one with a long strobe so the FIFO can back up and overflow.
//             Expected writes are queued as frames are driven and popped
//             on each rising cfg_strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_spi_loader;

   localparam int S_A   = 4;
   localparam int S_B   = 100;
   localparam int DEPTH = 4;

   logic       clk;
   logic       reset_a;
   logic       reset_b;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       cs_a;
   logic       cs_b;

   logic [3:0] a_addr;
   logic [7:0] a_data;
   logic       a_strobe;
   logic       a_busy;
   logic       a_overflow;
   logic [3:0] b_addr;
   logic [7:0] b_data;
   logic       b_strobe;
   logic       b_busy;
   logic       b_overflow;

   cfg_spi_loader #(.FIFO_DEPTH(DEPTH), .STROBE_CYCLES(S_A)) u_dut_a (
      .clk        (clk),
      .reset      (reset_a),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_cs_n   (cs_a),
      .cfg_addr   (a_addr),
      .cfg_data   (a_data),
      .cfg_strobe (a_strobe),
      .busy       (a_busy),
      .overflow   (a_overflow)
   );

   cfg_spi_loader #(.FIFO_DEPTH(DEPTH), .STROBE_CYCLES(S_B)) u_dut_b (
      .clk        (clk),
      .reset      (reset_b),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_cs_n   (cs_b),
      .cfg_addr   (b_addr),
      .cfg_data   (b_data),
      .cfg_strobe (b_strobe),
      .busy       (b_busy),
      .overflow   (b_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] q_a [$];
   logic [11:0] q_b [$];
   logic [7:0]  tx_buf [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode 0: data set while sclk low, sampled on rising sclk (clk/4).
   task automatic spi_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         spi_mosi = b[7-i];
         tick(2);
         spi_sclk = 1'b1;
         tick(2);
         spi_sclk = 1'b0;
      end
   endtask

   // Header + n data bytes from tx_buf; the first n_acc bytes are expected
   // to be written, at addresses counting up from hdr[3:0] mod 16.
   task automatic send_frame(input bit sel_b, input logic [7:0] hdr, input int n,
                             input int n_acc, input int partial);
      logic [3:0] p;
      if (sel_b) cs_b = 1'b0; else cs_a = 1'b0;
      tick(2);
      spi_bits(hdr, 8);
      p = hdr[3:0];
      for (int i = 0; i < n; i++) begin
         if (i < n_acc) begin
            if (sel_b) q_b.push_back({p, tx_buf[i]});
            else       q_a.push_back({p, tx_buf[i]});
         end
         spi_bits(tx_buf[i], 8);
         p = p + 4'd1;
      end
      if (partial > 0) spi_bits(8'hC3, partial);
      tick(4);
      if (sel_b) cs_b = 1'b1; else cs_a = 1'b1;
      spi_mosi = 1'b0;
      tick(2);
   endtask

   // which: 0 = a_busy, 1 = b_busy, 2 = b_strobe
   task automatic wait_sig(input int which, input logic lvl, input int budget, input string tag);
      logic v;
      bit   hit;
      v   = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < budget && !hit; k++) begin
         @(posedge clk);
         #1;
         v = (which == 0) ? a_busy : ((which == 1) ? b_busy : b_strobe);
         if (v === lvl) hit = 1'b1;
      end
      if (!hit) check({tag, "_timeout"}, {31'b0, v}, {31'b0, lvl});
   endtask

   // ------------------------------------------------------------------
   // Write monitors
   // ------------------------------------------------------------------
   logic        a_prev_stb = 1'b0;
   int          a_hi       = 0;
   int          a_rises    = 0;
   longint      a_last_rise = 0;
   logic [11:0] a_prev_out = '0;
   logic [11:0] a_held     = '0;
   logic [11:0] a_exp;

   always @(posedge clk) begin
      #1;
      if (reset_a) begin
         a_prev_stb = 1'b0;
         a_hi       = 0;
      end else begin
         if (a_strobe && !a_prev_stb) begin
            a_rises++;
            a_last_rise = cyc;
            a_hi        = 1;
            a_held      = {a_addr, a_data};
            check("a_setup_stable", a_held, a_prev_out);
            if (q_a.size() != 0) a_exp = q_a.pop_front();
            else                 a_exp = 12'bx;
            check("a_write_entry", a_held, a_exp);
         end else if (a_strobe) begin
            a_hi++;
            check("a_high_stable", {a_addr, a_data}, a_held);
         end else if (a_prev_stb) begin
            check("a_strobe_width", a_hi, S_A);
            check("a_hold_stable", {a_addr, a_data}, a_held);
         end
         a_prev_stb = a_strobe;
      end
      a_prev_out = {a_addr, a_data};
   end

   logic        b_prev_stb = 1'b0;
   int          b_hi       = 0;
   int          b_rises    = 0;
   longint      b_last_rise = 0;
   logic [11:0] b_held     = '0;
   logic [11:0] b_exp;
   bit          b_sp_on    = 1'b0;
   int          b_sp_base  = 0;

   always @(posedge clk) begin
      #1;
      if (reset_b) begin
         b_prev_stb = 1'b0;
         b_hi       = 0;
      end else begin
         if (b_strobe && !b_prev_stb) begin
            b_rises++;
            if (b_sp_on && b_rises >= b_sp_base + 2)
               check("b_write_spacing", 32'(cyc - b_last_rise), 2 + 2 * S_B);
            b_last_rise = cyc;
            b_hi        = 1;
            b_held      = {b_addr, b_data};
            if (q_b.size() != 0) b_exp = q_b.pop_front();
            else                 b_exp = 12'bx;
            check("b_write_entry", b_held, b_exp);
         end else if (b_strobe) begin
            b_hi++;
         end else if (b_prev_stb) begin
            check("b_strobe_width", b_hi, S_B);
            check("b_hold_stable", {b_addr, b_data}, b_held);
         end
         b_prev_stb = b_strobe;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      reset_a  = 1'b1;
      reset_b  = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      cs_a     = 1'b1;
      cs_b     = 1'b1;
      tick(3);
      check("rst_a_addr",     a_addr, 4'h0);
      check("rst_a_data",     a_data, 8'h00);
      check("rst_a_strobe",   a_strobe, 1'b0);
      check("rst_a_busy",     a_busy, 1'b0);
      check("rst_a_overflow", a_overflow, 1'b0);
      check("rst_b_strobe",   b_strobe, 1'b0);
      reset_a = 1'b0;
      reset_b = 1'b0;
      tick(4);

      // Single write: header 0x04, data 0xA5
      tx_buf[0] = 8'hA5;
      send_frame(1'b0, 8'h04, 1, 1, 0);
      wait_sig(0, 1'b1, 100, "t1_busy_rise");
      wait_sig(0, 1'b0, 100, "t1_busy_fall");
      check("t1_busy_fall_time", 32'(cyc - a_last_rise), 2 * S_A + 1);
      check("t1_write_count", a_rises, 1);

      // Pointer wrap: 0x0E -> addresses 14, 15, 0
      tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
      send_frame(1'b0, 8'h0E, 3, 3, 0);
      wait_sig(0, 1'b0, 200, "t2_idle");
      check("t2_write_count", a_rises, 4);
      check("t2_queue_empty", q_a.size(), 0);

      // Partial byte discarded, then a fresh frame
      tx_buf[0] = 8'h5A;
      send_frame(1'b0, 8'h03, 1, 1, 5);
      tick(20);
      wait_sig(0, 1'b0, 200, "t3a_idle");
      tx_buf[0] = 8'h3C;
      send_frame(1'b0, 8'h07, 1, 1, 0);
      tick(4);
      wait_sig(0, 1'b0, 200, "t3b_idle");
      check("t3_write_count", a_rises, 6);
      check("t3_a_overflow", a_overflow, 1'b0);
      check("t3_queue_empty", q_a.size(), 0);

      // Overflow on the slow instance: 6 bytes, 1 in flight + 4 buffered
      for (int i = 0; i < 6; i++) tx_buf[i] = 8'h81 + 8'(i);
      b_sp_base = b_rises;
      b_sp_on   = 1'b1;
      send_frame(1'b1, 8'h09, 6, 5, 0);
      check("t4_overflow_set", b_overflow, 1'b1);
      wait_sig(1, 1'b0, 3000, "t4_drain");
      b_sp_on = 1'b0;
      check("t4_write_count", b_rises, 5);
      check("t4_queue_empty", q_b.size(), 0);
      check("t4_overflow_sticky", b_overflow, 1'b1);
      check("t4_a_untouched", a_overflow, 1'b0);

      // Reset in the middle of HIGH with entries still buffered
      tx_buf[0] = 8'h44; tx_buf[1] = 8'h55; tx_buf[2] = 8'h66;
      send_frame(1'b1, 8'h02, 3, 3, 0);
      wait_sig(2, 1'b1, 300, "t5_strobe_rise");
      repeat (3) @(posedge clk);
      #3;
      reset_b = 1'b1;
      #1;
      check("t5_strobe_dropped", b_strobe, 1'b0);
      check("t5_busy_clear",     b_busy, 1'b0);
      check("t5_overflow_clear", b_overflow, 1'b0);
      check("t5_addr_clear",     b_addr, 4'h0);
      check("t5_data_clear",     b_data, 8'h00);
      check("t5_pending",        q_b.size(), 2);
      q_b.delete();
      tick(2);
      reset_b = 1'b0;
      tick(600);
      check("t5_no_more_writes", b_rises, 6);
      check("t5_busy_after",     b_busy, 1'b0);
      check("end_queue_a",       q_a.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
